// File: rtl/binary_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter.
// One operand bit per clock, start/done/ack handshake, overflow flag.
module binary_to_bcd_seq #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ack,
  input  logic [WIDTH-1:0]      binary,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opnd;
  logic [BW-1:0]    work;
  logic [BW-1:0]    corr;
  logic [BW-1:0]    nxt;
  logic             acc;
  logic             carry;
  logic [CW-1:0]    count;

  // Per-digit +3 correction, no carry between digits.
  always_comb begin
    corr = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5)
        corr[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
  end

  assign carry = corr[BW-1];
  assign nxt   = {corr[BW-2:0], opnd[WIDTH-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      opnd     <= '0;
      work     <= '0;
      acc      <= 1'b0;
      count    <= '0;
      bcd      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opnd  <= binary;
            work  <= '0;
            acc   <= 1'b0;
            count <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          work  <= nxt;
          opnd  <= opnd << 1;
          acc   <= acc | carry;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd      <= nxt;
            overflow <= acc | carry;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here, even alongside ack
          if (ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed self-checking bench for binary_to_bcd_seq.
// Instance a: 12-bit/4-digit defaults; instance b: 12-bit/3-digit.
module tb_binary_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start_a, ack_a;
  logic [11:0] binary_a;
  logic [15:0] bcd_a;
  logic        done_a, busy_a, overflow_a;
  logic        start_b, ack_b;
  logic [11:0] binary_b;
  logic [11:0] bcd_b;
  logic        done_b, busy_b, overflow_b;

  int total = 0;
  int bad   = 0;

  binary_to_bcd_seq #(.WIDTH(12), .DIGITS(4)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .ack(ack_a),
    .binary(binary_a), .bcd(bcd_a), .done(done_a),
    .busy(busy_a), .overflow(overflow_a)
  );

  binary_to_bcd_seq #(.WIDTH(12), .DIGITS(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .ack(ack_b),
    .binary(binary_b), .bcd(bcd_b), .done(done_b),
    .busy(busy_b), .overflow(overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Launch on a, switch binary to alt after accept, wait for done.
  task automatic run_a(input logic [11:0] v,
                       input logic [11:0] alt,
                       output int cyc);
    @(negedge clk);
    binary_a = v;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    binary_a = alt;
    cyc = 0;
    while (!done_a && cyc < 100) begin
      if (busy_a) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_b(input logic [11:0] v);
    int n;
    @(negedge clk);
    binary_b = v;
    start_b  = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b_done", done_b, 1);
  endtask

  task automatic ack_a_pulse();
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    chk("a_ack_done", done_a, 0);
  endtask

  task automatic ack_b_pulse();
    ack_b = 1'b1;
    @(negedge clk);
    ack_b = 1'b0;
    chk("b_ack_done", done_b, 0);
  endtask

  initial begin
    int cyc;
    int stable;
    int idx, seen, last, cnt;
    bit prev_done;
    logic [11:0] vals [4];
    logic [15:0] exps [4];

    vals = '{12'd7, 12'd10, 12'd99, 12'd100};
    exps = '{16'h0007, 16'h0010, 16'h0099, 16'h0100};

    reset = 1'b1;
    start_a = 0; ack_a = 0; binary_a = 0;
    start_b = 0; ack_b = 0; binary_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovf", overflow_a, 0);
    reset = 1'b0;

    // Full scale; busy must last exactly 12 cycles.
    run_a(12'd4095, 12'd4095, cyc);
    chk("fs_busy_cyc", cyc, 12);
    chk("fs_done", done_a, 1);
    chk("fs_bcd", bcd_a, 16'h4095);
    chk("fs_ovf", overflow_a, 0);

    // Hold in DONE for 50 cycles with a stray start pulse.
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      start_a  = (i == 10);
      binary_a = 12'd7;
      @(negedge clk);
      if (done_a !== 1'b1 || bcd_a !== 16'h4095 ||
          busy_a !== 1'b0 || overflow_a !== 1'b0)
        stable = 0;
    end
    start_a = 1'b0;
    chk("hold_stable", stable, 1);

    // start together with ack must be ignored.
    start_a = 1'b1;
    ack_a   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ack_a   = 1'b0;
    chk("ack_done_low", done_a, 0);
    chk("ack_no_start", busy_a, 0);
    chk("ack_bcd_keep", bcd_a, 16'h4095);
    @(negedge clk);
    chk("idle_no_start", busy_a, 0);

    run_a(12'd0, 12'd0, cyc);
    chk("zero_bcd", bcd_a, 16'h0000);
    chk("zero_ovf", overflow_a, 0);
    ack_a_pulse();

    // Operand is captured at start.
    run_a(12'd1234, 12'd999, cyc);
    chk("cap_bcd", bcd_a, 16'h1234);
    ack_a_pulse();

    // Three-digit instance: overflow boundary.
    run_b(12'd1234);
    chk("ov1234_bcd", bcd_b, 12'h234);
    chk("ov1234_ovf", overflow_b, 1);
    ack_b_pulse();
    run_b(12'd999);
    chk("ov999_bcd", bcd_b, 12'h999);
    chk("ov999_ovf", overflow_b, 0);
    ack_b_pulse();
    run_b(12'd1000);
    chk("ov1000_bcd", bcd_b, 12'h000);
    chk("ov1000_ovf", overflow_b, 1);
    ack_b_pulse();

    // Reset during the 5th CONVERT cycle.
    @(negedge clk);
    binary_a = 12'd4095;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy_a, 1);
    #1 reset = 1'b1;
    #1;
    chk("mrst_bcd", bcd_a, 0);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_done", done_a, 0);
    chk("mrst_ovf", overflow_a, 0);
    @(negedge clk);
    reset = 1'b0;
    run_a(12'd58, 12'd58, cyc);
    chk("post_rst_cyc", cyc, 12);
    chk("post_rst_bcd", bcd_a, 16'h0058);
    ack_a_pulse();

    // Back-to-back with ack held high.
    @(negedge clk);
    ack_a    = 1'b1;
    binary_a = vals[0];
    start_a  = 1'b1;
    idx = 1; seen = 0; last = -1; cnt = 0;
    prev_done = 0;
    while (seen < 4 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      start_a = 1'b0;
      if (prev_done) chk("b2b_pulse", done_a, 0);
      prev_done = done_a;
      if (done_a) begin
        chk("b2b_bcd", bcd_a, exps[seen]);
        if (last >= 0) chk("b2b_gap", cnt - last, 14);
        last = cnt;
        seen++;
      end else if (!busy_a && idx < 4) begin
        binary_a = vals[idx];
        start_a  = 1'b1;
        idx++;
      end
    end
    chk("b2b_count", seen, 4);
    ack_a = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
